s8_xor_byte_feeder_4bits: RTL

//  Byte-level driver and collector for the nibble-serial S8-and-XOR datapath of the 4-bit Enocoro-128v2 core.

---
 rtl/s8_xor_byte_feeder_4bits.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/s8_xor_byte_feeder_4bits.sv
// Byte-to-nibble feeder/collector for the 4-bit S8+XOR datapath.
// Optional S8_FEED_STATS_EN adds a saturating popped-byte counter.
module s8_xor_byte_feeder_4bits #(
  parameter int PIPE_LAT  = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_s8,
  input  logic [7:0] in_xor,
  output logic [3:0] to_s8,
  output logic [3:0] to_xor,
  output logic       mc_a,
  output logic       mc_b,
  input  logic [3:0] xor_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
`ifdef S8_FEED_STATS_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } state_t;

  state_t        state;
  logic [3:0]    s8_lo;
  logic [3:0]    xor_lo;
  logic [CW-1:0] credits;
  logic          accept;
  logic          pop;

  assign in_ready = reset_n
                  && (state != HI)
                  && (credits < CW'(OUT_DEPTH));
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      to_s8  <= '0;
      to_xor <= '0;
      mc_a   <= 1'b0;
      mc_b   <= 1'b0;
      s8_lo  <= '0;
      xor_lo <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          state  <= HI;
          to_s8  <= in_s8[7:4];
          to_xor <= in_xor[7:4];
          mc_a   <= 1'b1;
          mc_b   <= 1'b0;
          s8_lo  <= in_s8[3:0];
          xor_lo <= in_xor[3:0];
        end
        (state == HI): begin
          state  <= LO;
          to_s8  <= s8_lo;
          to_xor <= xor_lo;
          mc_a   <= 1'b0;
          mc_b   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          to_s8  <= '0;
          to_xor <= '0;
          mc_a   <= 1'b0;
          mc_b   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Tags follow each driven nibble so results are tied to their phase.
  logic [PIPE_LAT-1:0] tag_v;
  logic [PIPE_LAT-1:0] tag_hi;
  logic [3:0]          hold;
  logic                stage_v;
  logic                stage_hi;
  logic                push;

  assign stage_v  = tag_v[PIPE_LAT-1];
  assign stage_hi = tag_hi[PIPE_LAT-1];
  assign push     = stage_v && !stage_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v  <= '0;
      tag_hi <= '0;
      hold   <= '0;
    end else begin
      tag_v[0]  <= mc_a | mc_b;
      tag_hi[0] <= mc_a;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_hi[i] <= tag_hi[i-1];
      end
      if (stage_v && stage_hi) begin
        hold <= xor_in;
      end
    end
  end

  logic [7:0]    mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          load;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head byte moves into a registered output stage.
  assign load = (count != '0) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hold, xor_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(load);
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (load) begin
        rd_ptr    <= nxt(rd_ptr);
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef S8_FEED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= '0;
    end else if (pop && (byte_count != 16'hFFFF)) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`endif

endmodule
